// File: rtl/bus_pkg.sv
// ============================================================================
// Module  : bus_pkg
// Brief   : Shared response-kind and bridge-state types for the slave bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int RESP_KIND_W = 2;

    typedef enum logic [RESP_KIND_W-1:0] {
        RESP_READ = 2'd0,
        RESP_ERR  = 2'd1,
        RESP_WACK = 2'd2
    } resp_kind_e;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        BUS_REQ = 1'b1
    } bridge_state_e;

endpackage

`default_nettype wire

// File: rtl/resp_fifo.sv
// ============================================================================
// Module  : resp_fifo
// Brief   : Synchronous circular FIFO with a registered head, count and flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Reading the post-write image covers the push-into-empty bypass.
        head_d = mem_d[rd_ptr_d];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign data_o  = head_q;
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/serial_slave_bridge.sv
// ============================================================================
// Module  : serial_slave_bridge
// Brief   : Decoded-frame to parallel slave bus bridge with timeout and a
//           queued response path. Define SERIAL_SLAVE_BRIDGE_WRITE_ACK_EN to
//           acknowledge writes through the response FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_slave_bridge
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int RESP_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ERRCNT_WIDTH   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic                    req_we_i,
    input  logic                    req_err_i,
    output logic                    valid_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic                    we_o,
    input  logic                    ready_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    err_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [1:0]              resp_kind_o,
    output logic [ADDR_WIDTH-1:0]   resp_addr_o,
    output logic [DATA_WIDTH-1:0]   resp_data_o,
    output logic [ERRCNT_WIDTH-1:0] err_count_o
);

`ifdef SERIAL_SLAVE_BRIDGE_WRITE_ACK_EN
    localparam bit WACK_EN = 1'b1;
`else
    localparam bit WACK_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(RESP_DEPTH+1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef struct packed {
        resp_kind_e            kind;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } resp_entry_t;

    localparam int ENTRY_W = $bits(resp_entry_t);

    bridge_state_e           state_q, state_d;
    logic                    valid_q, valid_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [ERRCNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                    accept;
    logic                    expire;
    logic                    err_inc;
    logic                    push;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [ENTRY_W-1:0]      fifo_head;
    resp_entry_t             push_entry;
    resp_entry_t             head_entry;

    // Writes only need FIFO space when they will produce an acknowledge.
    assign req_ready_o = (state_q == IDLE) &&
                         ((fifo_count < CNT_W'(RESP_DEPTH)) || (req_we_i && !WACK_EN));
    assign accept      = req_valid_i && req_ready_o;
    assign expire      = (TIMEOUT_CYCLES != 0) && !ready_i &&
                         (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        tmo_d      = tmo_q;
        err_inc    = 1'b0;
        push       = 1'b0;
        push_entry = '{kind: RESP_ERR, addr: addr_q, data: '0};
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err_i) begin
                        err_inc         = 1'b1;
                        push            = !req_we_i || WACK_EN;
                        push_entry.addr = req_addr_i;
                    end else begin
                        state_d = BUS_REQ;
                        valid_d = 1'b1;
                        addr_d  = req_addr_i;
                        wdata_d = req_wdata_i;
                        we_d    = req_we_i;
                        tmo_d   = '0;
                    end
                end
            end
            BUS_REQ: begin
                if (ready_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    err_inc = err_i;
                    push    = !we_q || WACK_EN;
                    if (!err_i) begin
                        push_entry = '{kind: we_q ? RESP_WACK : RESP_READ,
                                       addr: addr_q,
                                       data: we_q ? wdata_q : rdata_i};
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    err_inc = 1'b1;
                    push    = !we_q || WACK_EN;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        err_cnt_d = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + ERRCNT_WIDTH'(1) : err_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            tmo_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            tmo_q     <= tmo_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push && !fifo_full),
        .data_i  (push_entry),
        .pop_i   (resp_ready_i),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_entry   = resp_entry_t'(fifo_head);
    assign valid_o      = valid_q;
    assign addr_o       = addr_q;
    assign wdata_o      = wdata_q;
    assign we_o         = we_q;
    assign resp_valid_o = !fifo_empty;
    assign resp_kind_o  = head_entry.kind;
    assign resp_addr_o  = head_entry.addr;
    assign resp_data_o  = head_entry.data;
    assign err_count_o  = err_cnt_q;

endmodule

`default_nettype wire
